// File: rtl/lsu_handshake.sv
// rtl/lsu_handshake.sv - sequential load/store unit with valid/ready memory handshake and split beats
module lsu_handshake #(
    parameter int XLEN           = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_err,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    output logic [XLEN/8-1:0]     mem_strobe,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  mem_rvalid
);
    localparam int WB   = XLEN / 8;
    localparam int OFFW = $clog2(WB);
    localparam int SW   = 2 * WB;

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic                  split_q, split_d;
    logic                  err_q, err_d;
    logic [XLEN-1:0]       rdata0_q, rdata0_d;
    logic [XLEN-1:0]       rdata1_q, rdata1_d;

    // Request decode, used only while IDLE
    logic [OFFW-1:0] req_off;
    logic [3:0]      req_size;
    logic            req_illegal;
    logic            req_cross;
    logic            req_err;
    logic            req_split;

    always_comb begin
        req_off     = req_addr[OFFW-1:0];
        req_size    = 4'd1 << req_funct3[1:0];
        req_illegal = (req_funct3 == 3'b111)
                   || ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)))
                   || (req_write && req_funct3[2]);
        req_cross   = (5'(req_off) + 5'(req_size)) > 5'(WB);
        req_err     = req_illegal || (req_cross && (MISALIGN_SPLIT == 0));
        req_split   = req_cross && (MISALIGN_SPLIT != 0) && !req_illegal;
    end

    // Beat data derived from the registered request; the upper halves feed beat 1
    logic [OFFW-1:0]       off;
    logic [3:0]            size;
    logic [ADDR_WIDTH-1:0] base;
    logic [SW-1:0]         strb_wide;
    logic [2*XLEN-1:0]     wdata_wide;
    logic [XLEN-1:0]       raw;
    logic [XLEN-1:0]       mask;
    logic [XLEN-1:0]       sign_src;
    logic                  sgn;
    logic [XLEN-1:0]       ext;
    int unsigned           nbits;

    always_comb begin
        off        = addr_q[OFFW-1:0];
        size       = 4'd1 << funct3_q[1:0];
        base       = {addr_q[ADDR_WIDTH-1:OFFW], OFFW'(0)};
        strb_wide  = (SW'(1) << size) - SW'(1);
        strb_wide  = strb_wide << off;
        wdata_wide = (2*XLEN)'(wdata_q) << (8 * off);
        raw        = XLEN'({rdata1_q, rdata0_q} >> (8 * off));
        nbits      = 32'd8 << funct3_q[1:0];
        mask       = (nbits >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
        sign_src   = raw >> (nbits - 1);
        sgn        = ~funct3_q[2] & sign_src[0];
        ext        = sgn ? (raw | ~mask) : (raw & mask);
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        mem_valid  = (state_q == REQ0) || (state_q == REQ1);
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_strobe = '0;
        if (state_q == REQ0) begin
            mem_write  = write_q;
            mem_addr   = base;
            mem_wdata  = wdata_wide[XLEN-1:0];
            mem_strobe = strb_wide[WB-1:0];
        end else if (state_q == REQ1) begin
            mem_write  = write_q;
            mem_addr   = base + ADDR_WIDTH'(WB);
            mem_wdata  = wdata_wide[2*XLEN-1:XLEN];
            mem_strobe = strb_wide[SW-1:WB];
        end
        resp_valid = (state_q == RESP);
        resp_err   = (state_q == RESP) && err_q;
        resp_rdata = ((state_q == RESP) && !err_q && !write_q) ? ext : '0;
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        split_d  = split_q;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    split_d  = req_split;
                    err_d    = req_err;
                    rdata0_d = '0;
                    rdata1_d = '0;
                    state_d  = req_err ? RESP : REQ0;
                end
            end
            REQ0: begin
                if (mem_ready) begin
                    if (write_q) state_d = split_q ? REQ1 : RESP;
                    else         state_d = WAIT0;
                end
            end
            WAIT0: begin
                if (mem_rvalid) begin
                    rdata0_d = mem_rdata;
                    state_d  = split_q ? REQ1 : RESP;
                end
            end
            REQ1: begin
                if (mem_ready) state_d = write_q ? RESP : WAIT1;
            end
            WAIT1: begin
                if (mem_rvalid) begin
                    rdata1_d = mem_rdata;
                    state_d  = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            split_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            split_q  <= split_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end
endmodule
